ioconfig_loader: RTL and testbench
==================================

# ioconfig_loader

Configuration loader for a bank of `N_IOB` IO blocks. It accepts a byte-serial configuration stream over a valid/ready handshake, checks each frame, and commits the per-block tristate mode (`TSMUX`, 2 bits) and input-path select (`DORREG`, 1 bit) atomically. It sits directly upstream of the IO block column and drives their configuration registers. Until the first good frame commits, every block stays at its power-on configuration: pad high-Z, combinational input path.

## Interface
Parameters:
- `N_IOB`, default 8: number of IO blocks configured; legal range 1..255.

Ports:
- `IOCLK`, in, 1: single clock. All state changes on the rising edge.
- `RST`, in, 1: reset, asynchronous and active-high.
- `CFG_DATA`, in, 8: stream byte.
- `CFG_VALID`, in, 1: `CFG_DATA` is valid.
- `CFG_READY`, out, 1: loader can accept a byte. A byte transfers on an edge where `CFG_VALID` and `CFG_READY` are both 1.
- `TSMUX_VEC`, out, 2*N_IOB: live tristate mode. IOB i uses bits [2i+1:2i].
- `DORREG_VEC`, out, N_IOB: live input select. IOB i uses bit i.
- `DONE`, out, 1: one-cycle pulse when a frame commits.
- `ERR`, out, 1: sticky frame error flag.

## Operation
- Frame format: `0xA5` (sync), START (first IOB index), COUNT, then COUNT payload bytes, then CHK.
- Payload byte: bits[1:0] are TSMUX, bit[2] is DORREG, bits[7:3] are reserved and must be 0.
- CHK is the XOR of START, COUNT and all payload bytes. Sync is excluded.
- FSM states:
  - HUNT: non-`0xA5` bytes are discarded. `0xA5` does the following: clears ERR, copies live vectors into shadow, clears the running XOR, then goes to START.
  - START: latch START into the index counter; XOR ← START. Go to COUNT.
  - COUNT:
    - If COUNT == 0 or START + COUNT > N_IOB (9-bit compare, no wrap), set ERR and go to HUNT.
    - Otherwise latch the remaining count and go to PAYLOAD.
  - PAYLOAD:
    - If reserved bits ≠ 0, set ERR and go to HUNT. Shadow is discarded.
    - Otherwise write the shadow entry at the index, then increment the index and decrement the remaining count.
    - On the last byte, go to CHECK.
  - CHECK:
    - If CHK == XOR, go to COMMIT.
    - Otherwise set ERR, go to HUNT, and leave live vectors unchanged.
  - COMMIT: shadow → live vectors. Go to HUNT.
- IOB entries outside [START, START+COUNT) keep their previous live values.
- After an error, the remaining bytes of the aborted frame are discarded in HUNT. A legal payload byte is always < `0x08`, so it cannot be taken for a sync. START, COUNT or CHK equal to `0xA5` can false-sync. Such a false sync fails the range or reserved-bit checks, or the checksum.
- Live vectors change only in COMMIT or on reset.

## Timing
- Reset values:
  - `TSMUX_VEC` = 0 and `DORREG_VEC` = 0, which gives pad high-Z and a combinational input path.
  - `DONE` = 0, `ERR` = 0, `CFG_READY` = 1.
  - State = HUNT. Shadow, XOR and counters = 0.
- `CFG_READY` is 1 in every state except COMMIT. It is registered, so it is low for exactly the one cycle in COMMIT.
- `CFG_VALID` may drop between any bytes. States hold while no transfer occurs.
- Latency:
  - CHK accepted at edge k: state = COMMIT in cycle k+1.
  - At edge k+1, live vectors update and DONE is registered high.
  - DONE is high for cycle k+2 only, coincident with the new vectors.
  - Back-to-back frames are legal. The sync of the next frame may transfer at edge k+2.
- ERR rises in the cycle after the offending byte transfers. It holds until the next accepted `0xA5`, and falls the cycle after that.
- Reset asserted mid-frame: everything returns to reset values immediately, so previous configuration is lost. The partial frame is discarded.

## Test plan
- Reset, then frame `A5 02 03 01 03 04 07` at `N_IOB`=8 with VALID held high:
  - `TSMUX_VEC`=`0x00D0`, `DORREG_VEC`=`0x10`.
  - DONE high for 1 cycle, 2 cycles after CHK transfers.
  - `CFG_READY` low for exactly 1 cycle. ERR=0.
- Same frame with CHK=`06`:
  - ERR=1, DONE never pulses, vectors keep their prior values.
  - A following good frame clears ERR and commits.
- Range error `A5 06 03 …`: ERR=1 after the COUNT byte. The next 4 bytes `00 01 02 05` are ignored, and vectors are unchanged. Repeat with COUNT=`00` and expect the same result.
- Reserved bits `A5 00 01 08 08`: ERR=1 after the payload byte. The trailing `08` is discarded and there is no commit.
- Partial update: first load all 8 IOBs with `02`, then send `A5 07 01 05 03`:
  - IOB7 gets TSMUX=01 and DORREG=1.
  - IOB0–6 stay at `02`.
  - Randomized `CFG_VALID` gaps give an identical result.
- `RST` pulsed asynchronously between the COUNT byte and the payload bytes: all outputs read 0 immediately. The rest of the frame is discarded, and a fresh frame commits normally.

Source files
------------

// File: rtl/ioconfig_loader.sv
// Byte-serial configuration loader for a column of IO blocks: frames are checked
// in a shadow copy and committed to the live TSMUX/DORREG vectors atomically.
module ioconfig_loader #(
    parameter int N_IOB = 8
) (
    input  logic                 IOCLK,
    input  logic                 RST,
    input  logic [7:0]           CFG_DATA,
    input  logic                 CFG_VALID,
    output logic                 CFG_READY,
    output logic [2*N_IOB-1:0]   TSMUX_VEC,
    output logic [N_IOB-1:0]     DORREG_VEC,
    output logic                 DONE,
    output logic                 ERR
);

    typedef enum logic [2:0] {
        S_HUNT    = 3'd0,
        S_START   = 3'd1,
        S_COUNT   = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CHECK   = 3'd4,
        S_COMMIT  = 3'd5
    } state_t;

    state_t               state_r;
    logic [2*N_IOB-1:0]   tsmux_r;
    logic [N_IOB-1:0]     dorreg_r;
    logic [2*N_IOB-1:0]   sh_tsmux_r;
    logic [N_IOB-1:0]     sh_dorreg_r;
    logic [7:0]           xor_r;
    logic [7:0]           idx_r;
    logic [7:0]           rem_r;
    logic                 done_r;
    logic                 err_r;
    logic                 ready_r;

    logic                 xfer_s;
    logic [8:0]           end_idx_s;

    // Handshake qualifier and the 9-bit frame end index (START + COUNT, no wrap)
    always_comb begin
        xfer_s    = CFG_VALID & ready_r;
        end_idx_s = {1'b0, idx_r} + {1'b0, CFG_DATA};
    end

    // Frame parser, shadow staging and atomic commit to the live vectors
    always_ff @(posedge IOCLK or posedge RST) begin
        if (RST) begin
            state_r     <= S_HUNT;
            tsmux_r     <= '0;
            dorreg_r    <= '0;
            sh_tsmux_r  <= '0;
            sh_dorreg_r <= '0;
            xor_r       <= 8'd0;
            idx_r       <= 8'd0;
            rem_r       <= 8'd0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            ready_r     <= 1'b1;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_HUNT: begin
                    if (xfer_s && (CFG_DATA == 8'hA5)) begin
                        err_r       <= 1'b0;
                        sh_tsmux_r  <= tsmux_r;
                        sh_dorreg_r <= dorreg_r;
                        xor_r       <= 8'd0;
                        state_r     <= S_START;
                    end
                end
                S_START: begin
                    if (xfer_s) begin
                        idx_r   <= CFG_DATA;
                        xor_r   <= CFG_DATA;
                        state_r <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (xfer_s) begin
                        if ((CFG_DATA == 8'd0) || (end_idx_s > 9'(N_IOB))) begin
                            err_r   <= 1'b1;
                            state_r <= S_HUNT;
                        end else begin
                            rem_r   <= CFG_DATA;
                            xor_r   <= xor_r ^ CFG_DATA;
                            state_r <= S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (xfer_s) begin
                        if (CFG_DATA[7:3] != 5'd0) begin
                            err_r   <= 1'b1;
                            state_r <= S_HUNT;
                        end else begin
                            // Index is bounded by the range check, so exactly one entry matches
                            for (int i = 0; i < N_IOB; i++) begin
                                if (idx_r == 8'(i)) begin
                                    sh_tsmux_r[2*i +: 2] <= CFG_DATA[1:0];
                                    sh_dorreg_r[i]       <= CFG_DATA[2];
                                end
                            end
                            idx_r <= idx_r + 8'd1;
                            rem_r <= rem_r - 8'd1;
                            xor_r <= xor_r ^ CFG_DATA;
                            if (rem_r == 8'd1) begin
                                state_r <= S_CHECK;
                            end
                        end
                    end
                end
                S_CHECK: begin
                    if (xfer_s) begin
                        if (CFG_DATA == xor_r) begin
                            ready_r <= 1'b0;
                            state_r <= S_COMMIT;
                        end else begin
                            err_r   <= 1'b1;
                            state_r <= S_HUNT;
                        end
                    end
                end
                S_COMMIT: begin
                    tsmux_r  <= sh_tsmux_r;
                    dorreg_r <= sh_dorreg_r;
                    done_r   <= 1'b1;
                    ready_r  <= 1'b1;
                    state_r  <= S_HUNT;
                end
                default: begin
                    ready_r <= 1'b1;
                    state_r <= S_HUNT;
                end
            endcase
        end
    end

    assign CFG_READY  = ready_r;
    assign TSMUX_VEC  = tsmux_r;
    assign DORREG_VEC = dorreg_r;
    assign DONE       = done_r;
    assign ERR        = err_r;

endmodule

// File: tb/tb_ioconfig_loader.sv
// Directed and randomized frame bench for ioconfig_loader with a frame-level
// reference model of the per-IOB configuration.
module tb_ioconfig_loader;

    localparam int N = 8;

    logic             IOCLK;
    logic             RST;
    logic [7:0]       CFG_DATA;
    logic             CFG_VALID;
    logic             CFG_READY;
    logic [2*N-1:0]   TSMUX_VEC;
    logic [N-1:0]     DORREG_VEC;
    logic             DONE;
    logic             ERR;

    int errors = 0;
    int checks = 0;

    logic [1:0] ref_ts [N];
    logic       ref_dr [N];
    logic [7:0] pl [$];

    ioconfig_loader #(.N_IOB(N)) dut (
        .IOCLK(IOCLK), .RST(RST), .CFG_DATA(CFG_DATA), .CFG_VALID(CFG_VALID),
        .CFG_READY(CFG_READY), .TSMUX_VEC(TSMUX_VEC), .DORREG_VEC(DORREG_VEC),
        .DONE(DONE), .ERR(ERR)
    );

    initial IOCLK = 1'b0;
    always #5 IOCLK = ~IOCLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_ts();
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < N; i++) v[2*i +: 2] = ref_ts[i];
        return v;
    endfunction

    function automatic logic [31:0] exp_dr();
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < N; i++) v[i] = ref_dr[i];
        return v;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int g;
        int w;
        g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        repeat (g) @(negedge IOCLK);
        @(negedge IOCLK);
        CFG_DATA  = b;
        CFG_VALID = 1'b1;
        w = 0;
        while (!CFG_READY && w < 20) begin
            @(negedge IOCLK);
            w++;
        end
        chk("ready_wait", 32'(w < 20), 32'd1);
        @(posedge IOCLK);
        #1;
        CFG_VALID = 1'b0;
    endtask

    // Sends one frame built from st/cnt/pl; chk byte is chk_v if explicit, else true XOR ^ chk_v
    task automatic run_frame(input string tag, input int st, input int cnt, input bit explicit,
                             input logic [7:0] chk_v, input bit tail, input int maxgap);
        logic [7:0] tx [$];
        logic [7:0] x;
        logic [7:0] c;
        logic [31:0] old_ts;
        logic [31:0] old_dr;
        logic d;
        int epos;
        int last;
        x = 8'(st) ^ 8'(cnt);
        tx.push_back(8'hA5);
        tx.push_back(8'(st));
        tx.push_back(8'(cnt));
        foreach (pl[j]) begin
            tx.push_back(pl[j]);
            x = x ^ pl[j];
        end
        c = explicit ? chk_v : (x ^ chk_v);
        tx.push_back(c);
        epos = -1;
        if (cnt == 0 || st + cnt > N) epos = 2;
        else begin
            for (int j = 0; j < cnt; j++)
                if (epos < 0 && pl[j] > 8'h07) epos = 3 + j;
            if (epos < 0 && c != x) epos = 3 + cnt;
        end
        old_ts = exp_ts();
        old_dr = exp_dr();
        last = (epos < 0 || tail) ? tx.size() - 1 : epos;
        for (int i = 0; i <= last; i++) begin
            send_byte(tx[i], maxgap);
            if (i == epos) chk({tag, "_err_rise"}, 32'(ERR), 32'd1);
        end
        if (epos < 0) begin
            for (int j = 0; j < cnt; j++) begin
                ref_ts[st + j] = pl[j][1:0];
                ref_dr[st + j] = pl[j][2];
            end
            chk({tag, "_ready_low"}, 32'(CFG_READY), 32'd0);
            chk({tag, "_done_early"}, 32'(DONE), 32'd0);
            chk({tag, "_ts_hold"}, 32'(TSMUX_VEC), old_ts);
            @(posedge IOCLK); #1;
            chk({tag, "_done"}, 32'(DONE), 32'd1);
            chk({tag, "_ts"}, 32'(TSMUX_VEC), exp_ts());
            chk({tag, "_dr"}, 32'(DORREG_VEC), exp_dr());
            chk({tag, "_err"}, 32'(ERR), 32'd0);
            @(posedge IOCLK); #1;
            chk({tag, "_done_fall"}, 32'(DONE), 32'd0);
            chk({tag, "_ready_back"}, 32'(CFG_READY), 32'd1);
        end else begin
            d = 1'b0;
            repeat (3) begin
                @(posedge IOCLK); #1;
                d = d | DONE;
            end
            chk({tag, "_no_done"}, 32'(d), 32'd0);
            chk({tag, "_err_hold"}, 32'(ERR), 32'd1);
            chk({tag, "_ts_keep"}, 32'(TSMUX_VEC), old_ts);
            chk({tag, "_dr_keep"}, 32'(DORREG_VEC), old_dr);
        end
    endtask

    task automatic fill_all(input logic [7:0] v);
        pl.delete();
        for (int j = 0; j < N; j++) pl.push_back(v);
    endtask

    initial begin
        int st;
        int cnt;
        int kind;
        int j;
        logic [7:0] m;
        for (int i = 0; i < N; i++) begin
            ref_ts[i] = 2'd0;
            ref_dr[i] = 1'b0;
        end
        RST       = 1'b1;
        CFG_VALID = 1'b0;
        CFG_DATA  = 8'd0;
        #12;
        chk("rst_ts", 32'(TSMUX_VEC), 32'd0);
        chk("rst_dr", 32'(DORREG_VEC), 32'd0);
        chk("rst_done", 32'(DONE), 32'd0);
        chk("rst_err", 32'(ERR), 32'd0);
        chk("rst_ready", 32'(CFG_READY), 32'd1);
        @(negedge IOCLK);
        RST = 1'b0;

        pl = '{8'h01, 8'h03, 8'h04};
        run_frame("basic", 2, 3, 1'b1, 8'h07, 1'b0, 0);
        chk("basic_ts_lit", 32'(TSMUX_VEC), 32'h00D0);
        chk("basic_dr_lit", 32'(DORREG_VEC), 32'h10);

        run_frame("badchk", 2, 3, 1'b1, 8'h06, 1'b0, 0);
        pl = '{8'h06, 8'h01};
        run_frame("recover", 0, 2, 1'b0, 8'h00, 1'b0, 0);

        pl = '{8'h00, 8'h01, 8'h02};
        run_frame("range", 6, 3, 1'b1, 8'h05, 1'b1, 0);
        run_frame("cnt0", 6, 0, 1'b1, 8'h05, 1'b1, 0);

        pl = '{8'h08};
        run_frame("resv", 0, 1, 1'b1, 8'h08, 1'b1, 0);

        fill_all(8'h02);
        run_frame("fill", 0, N, 1'b0, 8'h00, 1'b0, 0);
        pl = '{8'h05};
        run_frame("part", 7, 1, 1'b1, 8'h03, 1'b0, 0);
        chk("part_ts_lit", 32'(TSMUX_VEC), 32'h6AAA);
        chk("part_dr_lit", 32'(DORREG_VEC), 32'h80);
        fill_all(8'h02);
        run_frame("fill_gap", 0, N, 1'b0, 8'h00, 1'b0, 3);
        pl = '{8'h05};
        run_frame("part_gap", 7, 1, 1'b1, 8'h03, 1'b0, 3);
        chk("part_gap_ts_lit", 32'(TSMUX_VEC), 32'h6AAA);
        chk("part_gap_dr_lit", 32'(DORREG_VEC), 32'h80);

        // Asynchronous reset between COUNT and the payload bytes
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        #3 RST = 1'b1;
        #1;
        for (int i = 0; i < N; i++) begin
            ref_ts[i] = 2'd0;
            ref_dr[i] = 1'b0;
        end
        chk("arst_ts", 32'(TSMUX_VEC), 32'd0);
        chk("arst_dr", 32'(DORREG_VEC), 32'd0);
        chk("arst_ready", 32'(CFG_READY), 32'd1);
        chk("arst_err", 32'(ERR), 32'd0);
        chk("arst_done", 32'(DONE), 32'd0);
        #2 RST = 1'b0;
        send_byte(8'h03, 0);
        send_byte(8'h03, 0);
        send_byte(8'h03, 0);
        chk("arst_tail_ts", 32'(TSMUX_VEC), 32'd0);
        chk("arst_tail_err", 32'(ERR), 32'd0);
        pl = '{8'h07, 8'h03};
        run_frame("arst_fresh", 1, 2, 1'b0, 8'h00, 1'b0, 0);

        for (int f = 0; f < 24; f++) begin
            kind = int'($urandom_range(3, 0));
            st   = int'($urandom_range(N - 1, 0));
            m    = 8'h00;
            if (kind == 3) begin
                cnt = ($urandom_range(1, 0) == 0) ? 0 : (N + 1 - st) + int'($urandom_range(2, 0));
            end else begin
                cnt = int'($urandom_range(N - st, 1));
            end
            pl.delete();
            for (int k = 0; k < cnt; k++) pl.push_back(8'($urandom_range(7, 0)));
            if (kind == 2) begin
                j = int'($urandom_range(cnt - 1, 0));
                m = 8'h08;
                m = m << $urandom_range(4, 0);
                pl[j] = pl[j] | m;
                m = 8'h00;
            end
            if (kind == 1) m = 8'($urandom_range(255, 1));
            run_frame("rand", st, cnt, 1'b0, m, 1'b0, 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
